fwd_hazard_scoreboard: RTL and testbench



---
 rtl/fwd_pkg.sv | 29 ++
 rtl/fwd_hazard_scoreboard_if.sv | 33 +++
 rtl/fwd_hazard_scoreboard_match.sv | 34 +++
 rtl/fwd_hazard_scoreboard.sv | 98 +++++++++
 tb/tb_fwd_hazard_scoreboard.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard scoreboard and the
// datapath forward muxes that consume its selects.
package fwd_pkg;

  // Widest register address a pipe entry can hold; narrower tags are zero-extended.
  localparam int FWD_MAX_AW = 8;

  // Select value meaning "take the register-file read".
  localparam int FWD_RF = 0;

  localparam int FWD_REG_AW     = 3;
  localparam int FWD_NUM_SRC    = 3;
  localparam int FWD_DEPTH      = 3;
  localparam int FWD_LOAD_STAGE = 2;
  localparam int FWD_CNTW       = 16;

  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic                  is_load;
    logic [FWD_MAX_AW-1:0] dst;
  } fwd_entry_t;

  // Select width: encodes FWD_RF plus one value per tracked stage.
  function automatic int fwd_selw(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_if.sv
// ID-side request and EX-side forward-select bundle for the hazard scoreboard.
interface fwd_hazard_scoreboard_if import fwd_pkg::*; #(
  parameter int REG_AW  = FWD_REG_AW,
  parameter int NUM_SRC = FWD_NUM_SRC,
  parameter int DEPTH   = FWD_DEPTH,
  parameter int CNTW    = FWD_CNTW
);
  localparam int SELW = fwd_selw(DEPTH);

  logic                      id_valid;
  logic                      id_wr;
  logic                      id_is_load;
  logic [REG_AW-1:0]         id_dst;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic                      flush;

  logic                      stall;
  logic [NUM_SRC*SELW-1:0]   ex_fwd_sel;
  logic                      ex_fwd_valid;
  logic [CNTW-1:0]           stall_count;

  modport master (
    output id_valid, id_wr, id_is_load, id_dst, id_src, id_src_used, flush,
    input  stall, ex_fwd_sel, ex_fwd_valid, stall_count
  );

  modport slave (
    input  id_valid, id_wr, id_is_load, id_dst, id_src, id_src_used, flush,
    output stall, ex_fwd_sel, ex_fwd_valid, stall_count
  );

endinterface

// File: rtl/fwd_hazard_scoreboard_match.sv
// Per-source tag matcher: finds the youngest in-flight writer of one source
// tag and reports where it will sit when the consumer reaches EX.
module fwd_match import fwd_pkg::*; #(
  parameter int REG_AW = FWD_REG_AW,
  parameter int DEPTH  = FWD_DEPTH,
  parameter int SELW   = fwd_selw(FWD_DEPTH)
) (
  input  logic [REG_AW-1:0]      src_tag,
  input  logic                   src_used,
  input  fwd_entry_t [DEPTH-1:0] pipe,
  output logic                   hit,
  output logic [SELW-1:0]        sel,
  output logic                   hit_is_load
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    hit         = 1'b0;
    sel         = SELW'(FWD_RF);
    hit_is_load = 1'b0;
    // Walk oldest to youngest so the youngest match overwrites older ones.
    if (src_used && (src_tag != '0)) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (pipe[i].valid && pipe[i].wr && (pipe[i].dst == FWD_MAX_AW'(src_tag))) begin
          hit         = 1'b1;
          sel         = SELW'(i + 1);
          hit_is_load = pipe[i].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Registered forward-select and load-use stall generator, tracking a shadow
// of destination tags for every stage after ID.
module fwd_hazard_scoreboard import fwd_pkg::*; #(
  parameter int REG_AW     = FWD_REG_AW,
  parameter int NUM_SRC    = FWD_NUM_SRC,
  parameter int DEPTH      = FWD_DEPTH,
  parameter int LOAD_STAGE = FWD_LOAD_STAGE,
  parameter int CNTW       = FWD_CNTW
) (
  input logic                    clk,
  input logic                    rst,
  fwd_hazard_scoreboard_if.slave bus
);

  localparam int SELW = fwd_selw(DEPTH);

  fwd_entry_t [DEPTH-1:0]  p_q, p_d;
  logic [NUM_SRC*SELW-1:0] ex_fwd_sel_q, ex_fwd_sel_d;
  logic                    ex_fwd_valid_q, ex_fwd_valid_d;
  logic [CNTW-1:0]         stall_count_q, stall_count_d;

  logic [NUM_SRC-1:0]      hit;
  logic [NUM_SRC-1:0]      hit_is_load;
  logic [NUM_SRC-1:0]      load_use;
  logic [SELW-1:0]         sel [NUM_SRC];
  logic                    stall;
  logic                    enter;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_match
    fwd_match #(
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH),
      .SELW   (SELW)
    ) u_match (
      .src_tag     (bus.id_src[s*REG_AW +: REG_AW]),
      .src_used    (bus.id_src_used[s]),
      .pipe        (p_q),
      .hit         (hit[s]),
      .sel         (sel[s]),
      .hit_is_load (hit_is_load[s])
    );
  end

  always_comb begin
    load_use = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      // Only the winning (youngest) match is examined; an older ALU result
      // never masks a younger load.
      load_use[s] = hit[s] && hit_is_load[s] && (int'(sel[s]) < LOAD_STAGE);
    end

    stall = bus.id_valid && !bus.flush && (|load_use);
    enter = bus.id_valid && !stall && !bus.flush;

    p_d[0] = '{valid:   enter,
               wr:      bus.id_wr,
               is_load: bus.id_is_load,
               dst:     FWD_MAX_AW'(bus.id_dst)};
    for (int i = 1; i < DEPTH; i++) begin
      p_d[i] = p_q[i-1];
    end

    ex_fwd_sel_d = '0;
    if (enter) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        ex_fwd_sel_d[s*SELW +: SELW] = sel[s];
      end
    end
    ex_fwd_valid_d = enter;

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNTW{1'b1}})) begin
      stall_count_d = stall_count_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      p_q            <= '0;
      ex_fwd_sel_q   <= '0;
      ex_fwd_valid_q <= 1'b0;
      stall_count_q  <= '0;
    end else begin
      p_q            <= p_d;
      ex_fwd_sel_q   <= ex_fwd_sel_d;
      ex_fwd_valid_q <= ex_fwd_valid_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.ex_fwd_sel   = ex_fwd_sel_q;
  assign bus.ex_fwd_valid = ex_fwd_valid_q;
  assign bus.stall_count  = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench: dut1 uses default parameters, dut2 uses LOAD_STAGE=3 with a
// 2-bit stall counter to exercise the longer load stall and saturation.
module tb_fwd_hazard_scoreboard;
  import fwd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_scoreboard_if #(.REG_AW(3), .NUM_SRC(3), .DEPTH(3), .CNTW(16)) bus1 ();
  fwd_hazard_scoreboard_if #(.REG_AW(3), .NUM_SRC(3), .DEPTH(3), .CNTW(2))  bus2 ();

  fwd_hazard_scoreboard #(
    .REG_AW(3), .NUM_SRC(3), .DEPTH(3), .LOAD_STAGE(2), .CNTW(16)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  fwd_hazard_scoreboard #(
    .REG_AW(3), .NUM_SRC(3), .DEPTH(3), .LOAD_STAGE(3), .CNTW(2)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sel_of(input logic [5:0] v, input int s);
    logic [1:0] f;
    f = v[s*2 +: 2];
    return {30'b0, f};
  endfunction

  // Present one ID-stage instruction to dut d; srcs are A, B, C; used is {C,B,A}.
  task automatic drive(input int d, input logic v, input logic wr, input logic ld,
                       input logic [2:0] dst, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] c, input logic [2:0] used, input logic fl);
    if (d == 1) begin
      bus1.id_valid = v;  bus1.id_wr = wr;  bus1.id_is_load = ld;  bus1.id_dst = dst;
      bus1.id_src = {c, b, a};  bus1.id_src_used = used;  bus1.flush = fl;
    end else begin
      bus2.id_valid = v;  bus2.id_wr = wr;  bus2.id_is_load = ld;  bus2.id_dst = dst;
      bus2.id_src = {c, b, a};  bus2.id_src_used = used;  bus2.flush = fl;
    end
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic alu1(input logic [2:0] dst);
    drive(1, 1, 1, 0, dst, 0, 0, 0, 3'b000, 0);
    tick();
  endtask

  task automatic lw1(input logic [2:0] dst);
    drive(1, 1, 1, 1, dst, 0, 0, 0, 3'b000, 0);
    tick();
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    drive(2, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    tick();
    tick();
    check("rst_valid", bus1.ex_fwd_valid, 0);
    check("rst_sel",   bus1.ex_fwd_sel, 0);
    check("rst_count", bus1.stall_count, 0);
    check("rst_stall", bus1.stall, 0);
    rst = 1'b0;

    // Back-to-back ALU dependency: select 1 on A and B.
    alu1(3'd1);
    drive(1, 1, 1, 0, 3'd2, 3'd1, 3'd1, 3'd0, 3'b011, 0);
    check("d1_stall", bus1.stall, 0);
    tick();
    check("d1_valid", bus1.ex_fwd_valid, 1);
    check("d1_selA",  sel_of(bus1.ex_fwd_sel, 0), 1);
    check("d1_selB",  sel_of(bus1.ex_fwd_sel, 1), 1);
    check("d1_selC",  sel_of(bus1.ex_fwd_sel, 2), 0);

    // One unrelated instruction in between: select 2.
    alu1(3'd1);
    alu1(3'd5);
    drive(1, 1, 1, 0, 3'd2, 3'd1, 3'd1, 3'd0, 3'b011, 0);
    tick();
    check("d2_selA", sel_of(bus1.ex_fwd_sel, 0), 2);
    check("d2_selB", sel_of(bus1.ex_fwd_sel, 1), 2);

    // Two in between: select DEPTH (WB holding buffer).
    alu1(3'd1);
    alu1(3'd5);
    alu1(3'd6);
    drive(1, 1, 1, 0, 3'd2, 3'd1, 3'd1, 3'd0, 3'b011, 0);
    tick();
    check("d3_selA", sel_of(bus1.ex_fwd_sel, 0), 3);
    check("d3_selB", sel_of(bus1.ex_fwd_sel, 1), 3);

    // Load-use: one stall cycle, then forward from MEM/WB.
    lw1(3'd3);
    drive(1, 1, 1, 0, 3'd2, 3'd3, 3'd0, 3'd0, 3'b001, 0);
    check("lu_stall", bus1.stall, 1);
    tick();
    check("lu_bubble", bus1.ex_fwd_valid, 0);
    check("lu_count",  bus1.stall_count, 1);
    check("lu_stall2", bus1.stall, 0);
    tick();
    check("lu_valid", bus1.ex_fwd_valid, 1);
    check("lu_selA",  sel_of(bus1.ex_fwd_sel, 0), 2);
    check("lu_count2", bus1.stall_count, 1);

    // Unused B with a live tag, and tag 0 never matching an in-flight r0 writer.
    alu1(3'd1);
    drive(1, 1, 1, 0, 3'd2, 3'd1, 3'd1, 3'd0, 3'b001, 0);
    tick();
    check("imm_selA", sel_of(bus1.ex_fwd_sel, 0), 1);
    check("imm_selB", sel_of(bus1.ex_fwd_sel, 1), 0);
    alu1(3'd0);
    drive(1, 1, 1, 0, 3'd2, 3'd0, 3'd0, 3'd1, 3'b111, 0);
    check("r0_stall", bus1.stall, 0);
    tick();
    check("r0_selA", sel_of(bus1.ex_fwd_sel, 0), 0);
    check("r0_selB", sel_of(bus1.ex_fwd_sel, 1), 0);
    check("r0_selC", sel_of(bus1.ex_fwd_sel, 2), 3);

    // Youngest of two writers wins.
    alu1(3'd4);
    alu1(3'd4);
    drive(1, 1, 1, 0, 3'd2, 3'd4, 3'd0, 3'd0, 3'b001, 0);
    tick();
    check("young_selA", sel_of(bus1.ex_fwd_sel, 0), 1);

    // Younger load shadows an older, ready ALU result.
    alu1(3'd4);
    lw1(3'd4);
    drive(1, 1, 1, 0, 3'd2, 3'd4, 3'd0, 3'd0, 3'b001, 0);
    check("shadow_stall", bus1.stall, 1);
    tick();
    check("shadow_count", bus1.stall_count, 2);
    check("shadow_bubble", bus1.ex_fwd_valid, 0);
    tick();
    check("shadow_selA", sel_of(bus1.ex_fwd_sel, 0), 2);

    // Flush beats a load-use hazard; the flushed load must not enter p[0].
    lw1(3'd3);
    drive(1, 1, 1, 1, 3'd3, 3'd3, 3'd0, 3'd0, 3'b001, 1);
    check("fl_stall", bus1.stall, 0);
    tick();
    check("fl_valid", bus1.ex_fwd_valid, 0);
    check("fl_sel",   bus1.ex_fwd_sel, 0);
    check("fl_count", bus1.stall_count, 2);
    drive(1, 1, 1, 0, 3'd2, 3'd3, 3'd0, 3'd0, 3'b001, 0);
    check("fl_p0_invalid", bus1.stall, 0);
    tick();
    check("fl_next_valid", bus1.ex_fwd_valid, 1);
    check("fl_next_selA",  sel_of(bus1.ex_fwd_sel, 0), 2);

    // Asynchronous reset mid-stream with writers of r1 in flight.
    alu1(3'd1);
    alu1(3'd1);
    alu1(3'd1);
    drive(1, 1, 1, 0, 3'd2, 3'd1, 3'd0, 3'd0, 3'b001, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", bus1.ex_fwd_valid, 0);
    check("arst_sel",   bus1.ex_fwd_sel, 0);
    check("arst_count", bus1.stall_count, 0);
    check("arst_stall", bus1.stall, 0);
    tick();
    rst = 1'b0;
    drive(1, 0, 1, 0, 3'd2, 3'd1, 3'd0, 3'd0, 3'b001, 0);
    check("post_idle_stall", bus1.stall, 0);
    tick();
    check("post_idle_valid", bus1.ex_fwd_valid, 0);
    drive(1, 1, 1, 0, 3'd2, 3'd1, 3'd0, 3'd0, 3'b001, 0);
    check("post_stall", bus1.stall, 0);
    tick();
    check("post_valid", bus1.ex_fwd_valid, 1);
    check("post_selA",  sel_of(bus1.ex_fwd_sel, 0), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);

    // LOAD_STAGE=3: two stall cycles then select 3; 2-bit counter saturates at 3.
    drive(2, 1, 1, 1, 3'd3, 0, 0, 0, 3'b000, 0);
    tick();
    drive(2, 1, 1, 0, 3'd2, 3'd3, 3'd0, 3'd0, 3'b001, 0);
    check("ls3_stall1", bus2.stall, 1);
    tick();
    check("ls3_count1", bus2.stall_count, 1);
    check("ls3_stall2", bus2.stall, 1);
    tick();
    check("ls3_count2", bus2.stall_count, 2);
    check("ls3_stall3", bus2.stall, 0);
    tick();
    check("ls3_valid", bus2.ex_fwd_valid, 1);
    check("ls3_selA",  sel_of(bus2.ex_fwd_sel, 0), 3);
    drive(2, 1, 1, 1, 3'd3, 0, 0, 0, 3'b000, 0);
    tick();
    drive(2, 1, 1, 0, 3'd2, 3'd3, 3'd0, 3'd0, 3'b001, 0);
    tick();
    check("sat_count3", bus2.stall_count, 3);
    check("sat_stall", bus2.stall, 1);
    tick();
    check("sat_hold", bus2.stall_count, 3);
    drive(2, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
